// File: rtl/isc_ack_merge_if.sv
// Ack-merge bus: per-source ack pulses in, serialised ack pulse and status out.
// The slave side is the merger; the master side is whoever feeds and observes it.
interface isc_ack_merge_if #(
  parameter int SRC_NB = 4
);
  localparam int SRC_W = (SRC_NB > 1) ? $clog2(SRC_NB) : 1;

  logic [SRC_NB-1:0] in_pulse;
  logic              out_en;
  logic              ovf_clr;
  logic              out_pulse;
  logic [SRC_W-1:0]  out_src;
  logic              busy;
  logic              ovf;

  modport master (
    output in_pulse, out_en, ovf_clr,
    input  out_pulse, out_src, busy, ovf
  );

  modport slave (
    input  in_pulse, out_en, ovf_clr,
    output out_pulse, out_src, busy, ovf
  );
endinterface

// File: rtl/isc_ack_merge.sv
// Serialises simultaneous sync-ack pulses from SRC_NB sources into at most one
// pulse per cycle, with a saturating pending counter per source and round-robin grant.
module isc_ack_merge #(
  parameter int SRC_NB = 4,
  parameter int PEND_W = 3
) (
  input  logic           clk,
  input  logic           s_rst_n,
  isc_ack_merge_if.slave bus
);

  localparam int SRC_W = (SRC_NB > 1) ? $clog2(SRC_NB) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] r_pend [SRC_NB];
  logic [SRC_W-1:0]  r_rr;
  logic              r_out_pulse;
  logic [SRC_W-1:0]  r_out_src;
  logic              r_busy;
  logic              r_ovf;

  logic [SRC_NB-1:0] w_req;
  logic [SRC_NB-1:0] w_grant;
  logic [SRC_NB-1:0] w_sat;
  logic [SRC_NB-1:0] w_pend_nz;
  logic [SRC_W-1:0]  w_cand [SRC_NB];
  logic [PEND_W-1:0] w_pend_nxt [SRC_NB];
  logic              w_any_grant;
  logic [SRC_W-1:0]  w_grant_idx;

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a, input int b);
    int s;
    s = int'({1'b0, a}) + b;
    if (s >= SRC_NB) s = s - SRC_NB;
    return s[SRC_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < SRC_NB; gi++) begin : g_src
      // A fresh pulse is requestable in its arrival cycle, so bypassed acks never touch pend.
      assign w_req[gi]      = (r_pend[gi] != '0) | bus.in_pulse[gi];
      assign w_cand[gi]     = wrap_add(r_rr, gi);
      assign w_sat[gi]      = (r_pend[gi] == PEND_MAX) & bus.in_pulse[gi] & ~w_grant[gi];
      assign w_pend_nxt[gi] = w_sat[gi] ? r_pend[gi]
                            : r_pend[gi] + PEND_W'(bus.in_pulse[gi]) - PEND_W'(w_grant[gi]);
      assign w_pend_nz[gi]  = |w_pend_nxt[gi];
    end
  endgenerate

  always_comb begin
    w_any_grant = 1'b0;
    w_grant_idx = r_rr;
    w_grant     = '0;
    if (bus.out_en) begin
      for (int k = 0; k < SRC_NB; k++) begin
        if (!w_any_grant && w_req[w_cand[k]]) begin
          w_any_grant = 1'b1;
          w_grant_idx = w_cand[k];
        end
      end
    end
    if (w_any_grant) w_grant[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < SRC_NB; i++) r_pend[i] <= '0;
      r_rr        <= '0;
      r_out_pulse <= 1'b0;
      r_out_src   <= '0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      for (int i = 0; i < SRC_NB; i++) r_pend[i] <= w_pend_nxt[i];
      if (w_any_grant) begin
        r_rr      <= wrap_add(w_grant_idx, 1);
        r_out_src <= w_grant_idx;
      end
      r_out_pulse <= w_any_grant;
      r_busy      <= |w_pend_nz;
      // A drop in the same cycle as a clear keeps the flag set.
      if (|w_sat) r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.out_pulse = r_out_pulse;
  assign bus.out_src   = r_out_src;
  assign bus.busy      = r_busy;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_isc_ack_merge.sv
// Self-checking bench for isc_ack_merge: directed vector table, hand-written
// corner sequences, then random traffic against a count-based reference model.
module tb_isc_ack_merge;
  localparam int NB   = 4;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic s_rst_n;
  always #5 clk = ~clk;

  isc_ack_merge_if #(.SRC_NB(NB)) bus_if ();

  isc_ack_merge #(.SRC_NB(NB), .PEND_W(PW)) dut (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .bus     (bus_if.slave)
  );

  typedef struct {
    logic [NB-1:0] inp;
    logic          en;
    logic          clr;
    logic          e_pulse;
    logic [1:0]    e_src;
    logic          e_busy;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer counts per source
  int m_pend [NB];
  int m_rr;
  int m_pulse, m_src, m_busy, m_ovf;
  int m_in_total, m_drop_total;
  int dut_out_count;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [NB-1:0] inp, input logic en, input logic clr,
                              input logic p, input logic [1:0] s, input logic b, input logic o);
    vec_t v;
    v.inp = inp; v.en = en; v.clr = clr;
    v.e_pulse = p; v.e_src = s; v.e_busy = b; v.e_ovf = o;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_pend[i] = 0;
    m_rr = 0; m_pulse = 0; m_src = 0; m_busy = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic [NB-1:0] inp, input logic en, input logic clr);
    int g;
    int sat;
    g   = -1;
    sat = 0;
    if (en) begin
      for (int k = 0; k < NB; k++) begin
        int i;
        i = (m_rr + k) % NB;
        if (g < 0 && (m_pend[i] > 0 || inp[i])) g = i;
      end
    end
    m_busy = 0;
    for (int i = 0; i < NB; i++) begin
      int v;
      v = m_pend[i] + int'(inp[i]) - ((g == i) ? 1 : 0);
      if (inp[i]) m_in_total++;
      if (v > PMAX) begin
        v = PMAX;
        sat = 1;
        m_drop_total++;
      end
      m_pend[i] = v;
      if (v != 0) m_busy = 1;
    end
    m_pulse = (g >= 0) ? 1 : 0;
    if (g >= 0) begin
      m_src = g;
      m_rr  = (g + 1) % NB;
    end
    if (sat) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic cycle(input logic [NB-1:0] inp, input logic en, input logic clr, input string tag);
    bus_if.in_pulse = inp;
    bus_if.out_en   = en;
    bus_if.ovf_clr  = clr;
    model_step(inp, en, clr);
    @(posedge clk);
    #1;
    if (bus_if.out_pulse === 1'b1) dut_out_count++;
    $display("[%0t] %s in=%b en=%b clr=%b -> pulse=%b src=%0d busy=%b ovf=%b", $time, tag,
             inp, en, clr, bus_if.out_pulse, bus_if.out_src, bus_if.busy, bus_if.ovf);
    check({tag, ".out_pulse"}, int'(bus_if.out_pulse), m_pulse);
    check({tag, ".out_src"},   int'(bus_if.out_src),   m_src);
    check({tag, ".busy"},      int'(bus_if.busy),      m_busy);
    check({tag, ".ovf"},       int'(bus_if.ovf),       m_ovf);
  endtask

  task automatic do_reset();
    bus_if.in_pulse = '0;
    bus_if.out_en   = 1'b0;
    bus_if.ovf_clr  = 1'b0;
    s_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    s_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fair_cnt;
    int drain_cnt;
    int out_before;
    logic [NB-1:0] r_in;
    logic r_en, r_clr;

    // Directed table, starting from reset (rr pointer at 0)
    vecs.push_back(mk(4'b0010, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 1, 3, 0, 0));
    vecs.push_back(mk(4'b1111, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 1, 2, 1, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 0, 3, 0, 0));
    for (int k = 0; k < 7; k++) vecs.push_back(mk(4'b1000, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(4'b1000, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk(4'b1000, 0, 1, 0, 3, 1, 1));
    for (int k = 0; k < 6; k++) vecs.push_back(mk(4'b0000, 1, 0, 1, 3, 1, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 1, 3, 0, 1));
    vecs.push_back(mk(4'b0000, 1, 1, 0, 3, 0, 0));

    do_reset();
    check("reset.out_pulse", int'(bus_if.out_pulse), 0);
    check("reset.out_src",   int'(bus_if.out_src),   0);
    check("reset.busy",      int'(bus_if.busy),      0);
    check("reset.ovf",       int'(bus_if.ovf),       0);

    foreach (vecs[k]) begin
      bus_if.in_pulse = vecs[k].inp;
      bus_if.out_en   = vecs[k].en;
      bus_if.ovf_clr  = vecs[k].clr;
      @(posedge clk);
      #1;
      $display("[%0t] vec%0d in=%b en=%b clr=%b -> pulse=%b src=%0d busy=%b ovf=%b", $time, k,
               vecs[k].inp, vecs[k].en, vecs[k].clr,
               bus_if.out_pulse, bus_if.out_src, bus_if.busy, bus_if.ovf);
      check($sformatf("vec%0d.out_pulse", k), int'(bus_if.out_pulse), int'(vecs[k].e_pulse));
      check($sformatf("vec%0d.out_src", k),   int'(bus_if.out_src),   int'(vecs[k].e_src));
      check($sformatf("vec%0d.busy", k),      int'(bus_if.busy),      int'(vecs[k].e_busy));
      check($sformatf("vec%0d.ovf", k),       int'(bus_if.ovf),       int'(vecs[k].e_ovf));
    end

    // Fairness: sources 0 and 2 pulse every cycle; with 3-bit counters some acks saturate
    do_reset();
    fair_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0101, 1, 0, "fair");
      if (bus_if.out_pulse === 1'b1) fair_cnt++;
      check("fair.alt_src", int'(bus_if.out_src), (c % 2 == 0) ? 0 : 2);
    end
    check("fair.pulses_during", fair_cnt, 20);
    drain_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0000, 1, 0, "fair_drain");
      if (bus_if.out_pulse === 1'b1) begin
        drain_cnt++;
        check("fair_drain.alt_src", int'(bus_if.out_src), (c % 2 == 0) ? 0 : 2);
      end
    end
    check("fair.pulses_drain", drain_cnt, 14);
    check("fair.ovf_after", int'(bus_if.ovf), 1);

    // Async reset in the middle of a drain with pend = 3,2,0,1
    do_reset();
    cycle(4'b1011, 0, 0, "pre_rst");
    cycle(4'b0011, 0, 0, "pre_rst");
    cycle(4'b0001, 0, 0, "pre_rst");
    cycle(4'b0001, 0, 0, "pre_rst");
    cycle(4'b0000, 1, 0, "pre_rst");
    bus_if.out_en = 1'b1;
    #2;
    s_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async.out_pulse", int'(bus_if.out_pulse), 0);
    check("rst_async.out_src",   int'(bus_if.out_src),   0);
    check("rst_async.busy",      int'(bus_if.busy),      0);
    check("rst_async.ovf",       int'(bus_if.ovf),       0);
    #2;
    s_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) cycle(4'b0000, 1, 0, "post_rst");
    cycle(4'b0100, 1, 0, "post_rst_new");

    // Random traffic against the model, with alternating low/high out_en phases
    do_reset();
    m_in_total = 0;
    m_drop_total = 0;
    out_before = dut_out_count;
    for (int c = 0; c < 400; c++) begin
      r_in = NB'($urandom_range(0, (1 << NB) - 1));
      if (((c / 50) % 2) == 1) r_en = ($urandom_range(0, 3) == 0);
      else r_en = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 15) == 0);
      cycle(r_in, r_en, r_clr, "rand");
    end
    for (int c = 0; c < 40; c++) cycle('0, 1, 0, "rand_drain");
    check("rand.conservation", dut_out_count - out_before, m_in_total - m_drop_total);
    check("rand.idle_busy", int'(bus_if.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
